mem_arbiter_rr: RTL and testbench
=================================

MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requester ports, legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter DATA_WIDTH, default 32: data width.
REQ-004 Parameter PRIORITY_MODE, default 0: 0 = round-robin; 1 = fixed priority, lowest index wins.
REQ-005 Parameter TIMEOUT_CYCLES, default 0: memory wait limit in cycles; 0 disables the timeout.
REQ-006 There SHALL be one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 req_valid  in  NUM_PORTS  per-port request.
REQ-010 req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data; same packing as req_addr.
REQ-012 req_we  in  NUM_PORTS  per-port write enable.
REQ-013 grant  out  NUM_PORTS  one-hot owner of the bus, held for the whole transaction.
REQ-014 rsp_valid  out  NUM_PORTS  one-cycle completion pulse to the owning port.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data; valid when any rsp_valid bit is high.
REQ-016 rsp_err  out  1  timeout flag; valid with rsp_valid.
REQ-017 mem_req_valid  out  1  memory request.
REQ-018 mem_addr  out  ADDR_WIDTH  memory address.
REQ-019 mem_wdata  out  DATA_WIDTH  memory write data.
REQ-020 mem_we  out  1  memory write enable.
REQ-021 mem_data_valid  in  1  memory completion strobe.
REQ-022 mem_rdata  in  DATA_WIDTH  memory read data; sampled when mem_data_valid is high.

Function
REQ-023 The FSM SHALL have three states:
- IDLE: arbitrate.
- BUSY: transaction outstanding.
- RESP: one-cycle response.
REQ-024 In IDLE, if any req_valid bit is set, the block SHALL select one winner and enter BUSY on the next edge. With no request, it SHALL stay in IDLE.
REQ-025 On that edge, the winner's addr, wdata and we SHALL be registered into mem_addr, mem_wdata and mem_we; grant SHALL be set to the winner's one-hot value.
REQ-026 mem_req_valid SHALL be high exactly while the FSM is in BUSY.
- Latency is 1 cycle: request seen in IDLE at cycle t gives grant and mem_req_valid at t+1.
REQ-027 Captured fields SHALL stay stable through BUSY. Requester inputs are ignored after capture.
REQ-028 In BUSY, mem_data_valid=1 SHALL:
- capture mem_rdata into rsp_rdata;
- move the FSM to RESP.
REQ-029 RESP SHALL last exactly one cycle:
- rsp_valid[owner] = 1;
- grant still held;
- mem_req_valid = 0;
- then return to IDLE.
REQ-030 Back-to-back transactions SHALL be separated by a minimum of 1 IDLE cycle. A port still asserting req_valid in IDLE is treated as a new request.
REQ-031 Round-robin pointer rules (PRIORITY_MODE=0):
- the pointer holds the last granted index;
- the search starts at pointer+1 and wraps from NUM_PORTS-1 to 0;
- the pointer updates on entry to BUSY.
REQ-032 In PRIORITY_MODE=1 the lowest-index active requester SHALL win; the pointer is unused.
REQ-033 A request arriving while the FSM is in BUSY or RESP SHALL wait, with no grant, until the next IDLE arbitration.
REQ-034 Timeout (TIMEOUT_CYCLES>0):
- a counter clears on entry to BUSY and increments each BUSY cycle;
- when it reaches TIMEOUT_CYCLES without mem_data_valid, the FSM enters RESP with rsp_err=1 and rsp_rdata=0.
REQ-035 If mem_data_valid arrives in the same cycle the counter hits the limit, the data SHALL win and rsp_err=0.
REQ-036 mem_data_valid in IDLE or RESP SHALL be ignored.
REQ-037 grant SHALL be one-hot or zero in every cycle; rsp_valid SHALL never have more than one bit set.

Reset
REQ-038 reset=1 SHALL force the following on the next edge, including mid-transaction:
- FSM to IDLE;
- grant, rsp_valid, rsp_err and mem_req_valid to 0;
- mem_addr, mem_wdata, mem_we and rsp_rdata to 0;
- round-robin pointer to NUM_PORTS-1;
- timeout counter to 0.
REQ-039 A transaction aborted by reset SHALL produce no rsp_valid.

Verification (NUM_PORTS=4, TIMEOUT_CYCLES=8 unless stated)
REQ-040 Single read:
- stimulus: port0 req addr=0xDEADBEEF we=0; memory returns 0x12345678 3 cycles later;
- response: grant=0001 and mem_addr=0xDEADBEEF one cycle after the request; rsp_valid=0001 with rsp_rdata=0x12345678 one cycle after mem_data_valid.
REQ-041 Round-robin rotation:
- stimulus: all 4 ports hold req_valid continuously;
- response: grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-042 Fixed priority:
- stimulus: PRIORITY_MODE=1; ports 1 and 3 request continuously;
- response: port 1 is granted every time; port 3 is never granted.
REQ-043 Write:
- stimulus: port2 addr=0xCAFEBABE wdata=0x2468ACE0 we=1;
- response: mem_we=1 and mem_wdata=0x2468ACE0 held through BUSY.
REQ-044 Timeout:
- stimulus: memory never responds;
- response: rsp_valid to the owner and rsp_err=1 exactly 8 BUSY cycles after grant; rsp_rdata=0.
REQ-045 Reset mid-BUSY:
- stimulus: assert reset while port1 is granted;
- response: all outputs 0 after the next edge; no rsp_valid; after reset, a request from all ports grants port0 first.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// Multi-port memory arbiter: picks one requester (round-robin or fixed priority),
// forwards its request to a single memory port and returns a one-cycle response.
module mem_arbiter_rr #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRIORITY_MODE  = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS-1:0]             req_we,
  output logic [NUM_PORTS-1:0]             grant,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             mem_req_valid,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  output logic                             mem_we,
  input  logic                             mem_data_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_reg;
  logic [PW-1:0]       ptr_reg;
  logic [31:0]         tmo_cnt_reg;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Winner search: from ptr+1 with wrap in round-robin mode, from index 0 otherwise.
  logic          win_found;
  logic [PW-1:0] win_idx;
  int            cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (PRIORITY_MODE == 1) cand = k;
      else                    cand = (int'(ptr_reg) + 1 + k) % NUM_PORTS;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  wire tmo_hit = (TIMEOUT_CYCLES > 0) && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= PW'(NUM_PORTS - 1);
      tmo_cnt_reg   <= '0;
      grant         <= '0;
      rsp_valid     <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_we        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            state_reg     <= BUSY;
            grant         <= ONE_HOT0 << win_idx;
            mem_addr      <= addr_arr[win_idx];
            mem_wdata     <= wdata_arr[win_idx];
            mem_we        <= req_we[win_idx];
            mem_req_valid <= 1'b1;
            tmo_cnt_reg   <= '0;
            if (PRIORITY_MODE == 0) ptr_reg <= win_idx;
          end
        end
        BUSY: begin
          // Data arriving on the limit cycle takes precedence over the timeout.
          if (mem_data_valid) begin
            state_reg     <= RESP;
            mem_req_valid <= 1'b0;
            rsp_valid     <= grant;
            rsp_rdata     <= mem_rdata;
            rsp_err       <= 1'b0;
          end else if (tmo_hit) begin
            state_reg     <= RESP;
            mem_req_valid <= 1'b0;
            rsp_valid     <= grant;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b1;
          end else begin
            tmo_cnt_reg   <= tmo_cnt_reg + 32'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          grant     <= '0;
          rsp_valid <= '0;
          rsp_err   <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a round-robin instance and a fixed-priority
// instance share stimulus; expected values are hand-computed constants.
module tb_mem_arbiter_rr;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   req_valid;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]   req_we;
  logic            mem_data_valid;
  logic [DW-1:0]   mem_rdata;

  logic [NP-1:0] grant, rsp_valid, fp_grant, fp_rsp_valid;
  logic [DW-1:0] rsp_rdata, mem_wdata, fp_rsp_rdata, fp_mem_wdata;
  logic [AW-1:0] mem_addr, fp_mem_addr;
  logic          rsp_err, mem_req_valid, mem_we;
  logic          fp_rsp_err, fp_mem_req_valid, fp_mem_we;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) dut_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .grant(grant), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_req_valid(mem_req_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata));

  mem_arbiter_rr #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .grant(fp_grant), .rsp_valid(fp_rsp_valid),
    .rsp_rdata(fp_rsp_rdata), .rsp_err(fp_rsp_err), .mem_req_valid(fp_mem_req_valid),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_we(fp_mem_we),
    .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Memory completion pulse, then through RESP back to IDLE.
  task automatic finish_txn(input logic [DW-1:0] data);
    mem_data_valid = 1'b1;
    mem_rdata      = data;
    step();
    mem_data_valid = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0; req_we = '0;
    mem_data_valid = 1'b0; mem_rdata = '0;
    step(); step();
    reset = 1'b0;
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_mreq", 64'(mem_req_valid), 64'h0);
    chk("reset_rsp", 64'(rsp_valid), 64'h0);
    chk("reset_addr", 64'(mem_addr), 64'h0);

    // memory strobe while idle must not produce a response
    mem_data_valid = 1'b1; mem_rdata = 32'h5555AAAA;
    step();
    mem_data_valid = 1'b0;
    chk("idle_dv_ignored", 64'(rsp_valid), 64'h0);

    // single read
    req_valid = 4'b0001; req_addr[0*AW +: AW] = 32'hDEADBEEF; req_we = '0;
    step();
    req_valid = '0;
    chk("rd_grant", 64'(grant), 64'h1);
    chk("rd_mreq", 64'(mem_req_valid), 64'h1);
    chk("rd_addr", 64'(mem_addr), 64'hDEADBEEF);
    chk("rd_we", 64'(mem_we), 64'h0);
    step(); step();
    mem_data_valid = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_data_valid = 1'b0;
    chk("rd_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("rd_rdata", 64'(rsp_rdata), 64'h12345678);
    chk("rd_err", 64'(rsp_err), 64'h0);
    chk("rd_resp_grant", 64'(grant), 64'h1);
    chk("rd_resp_mreq", 64'(mem_req_valid), 64'h0);
    step();
    chk("rd_idle_grant", 64'(grant), 64'h0);
    chk("rd_idle_rsp", 64'(rsp_valid), 64'h0);

    // round-robin rotation with all ports requesting
    do_reset();
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("rr_grant%0d", n), 64'(grant), 64'(4'b0001 << (n % 4)));
      finish_txn(32'h0);
      chk($sformatf("rr_gap%0d", n), 64'(grant), 64'h0);
    end
    req_valid = '0;
    step();

    // fixed priority vs round-robin with ports 1 and 3 requesting
    do_reset();
    req_valid = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("fp_grant%0d", n), 64'(fp_grant), 64'h2);
      chk($sformatf("rr13_grant%0d", n), 64'(grant), (n == 1) ? 64'h8 : 64'h2);
      finish_txn(32'hA5A5A5A5);
      chk($sformatf("fp_rdata%0d", n), 64'(fp_rsp_rdata), 64'hA5A5A5A5);
    end
    req_valid = '0;
    step();

    // write; later requester changes and a new port-0 request are ignored in BUSY
    req_valid = 4'b0100; req_addr[2*AW +: AW] = 32'hCAFEBABE;
    req_wdata[2*DW +: DW] = 32'h2468ACE0; req_we = 4'b0100;
    step();
    chk("wr_grant", 64'(grant), 64'h4);
    chk("wr_we", 64'(mem_we), 64'h1);
    chk("wr_wdata", 64'(mem_wdata), 64'h2468ACE0);
    req_valid = 4'b0001; req_addr[2*AW +: AW] = 32'h0; req_wdata[2*DW +: DW] = 32'h0;
    req_we = '0; req_addr[0*AW +: AW] = 32'h11111111;
    step(); step();
    chk("wr_hold_grant", 64'(grant), 64'h4);
    chk("wr_hold_we", 64'(mem_we), 64'h1);
    chk("wr_hold_wdata", 64'(mem_wdata), 64'h2468ACE0);
    chk("wr_hold_addr", 64'(mem_addr), 64'hCAFEBABE);
    finish_txn(32'h9ABCDEF0);
    chk("wait_gap", 64'(grant), 64'h0);
    step();
    chk("wait_grant", 64'(grant), 64'h1);
    chk("wait_addr", 64'(mem_addr), 64'h11111111);
    req_valid = '0;
    finish_txn(32'h9ABCDEF0);

    // timeout: no memory response; response 8 cycles after grant
    req_valid = 4'b0001; mem_rdata = 32'h77777777;
    step();
    req_valid = '0;
    chk("to_grant", 64'(grant), 64'h1);
    for (int n = 1; n < 8; n++) begin
      step();
      chk($sformatf("to_wait%0d", n), 64'({mem_req_valid, rsp_valid}), 64'h10);
    end
    step();
    chk("to_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("to_err", 64'(rsp_err), 64'h1);
    chk("to_rdata", 64'(rsp_rdata), 64'h0);
    step();
    chk("to_idle_err", 64'(rsp_err), 64'h0);

    // data on the limit cycle wins over the timeout
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    for (int n = 1; n < 8; n++) step();
    mem_data_valid = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    mem_data_valid = 1'b0;
    chk("lim_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("lim_err", 64'(rsp_err), 64'h0);
    chk("lim_rdata", 64'(rsp_rdata), 64'h0BADF00D);
    step();

    // reset while port 1 owns the bus
    do_reset();
    req_valid = 4'b0010; req_addr[1*AW +: AW] = 32'h13572468;
    req_wdata[1*DW +: DW] = 32'hFFFF0000; req_we = 4'b0010;
    step();
    req_valid = '0;
    chk("rst_mid_grant_before", 64'(grant), 64'h2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_grant", 64'(grant), 64'h0);
    chk("rst_mid_mreq", 64'(mem_req_valid), 64'h0);
    chk("rst_mid_fields", 64'({mem_addr, mem_we}), 64'h0);
    chk("rst_mid_wdata", 64'(mem_wdata), 64'h0);
    chk("rst_mid_rsp", 64'({rsp_valid, rsp_err}), 64'h0);
    chk("rst_mid_rdata", 64'(rsp_rdata), 64'h0);
    mem_data_valid = 1'b1;
    req_valid = 4'b1111;
    step();
    mem_data_valid = 1'b0;
    chk("rst_after_rsp", 64'(rsp_valid), 64'h0);
    chk("rst_after_grant", 64'(grant), 64'h1);
    req_valid = '0;
    finish_txn(32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
